// File: rtl/pic_pkg.sv
// Shared types and helpers for the priority-interrupt core.
package pic_pkg;

    localparam int VEC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_ACK2
    } pic_state_t;

    // Rank 0 is the highest priority: the channel just after lowest_ptr.
    function automatic int prio_rank(input int id, input int lowest_ptr, input int n);
        return (id - lowest_ptr - 1) & (n - 1);
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating-priority encoder: finds the first set request after lowest_ptr.
module pic_prio_resolver #(
    parameter  int N_IRQ = 8,
    localparam int ID_W  = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [ID_W-1:0]  lowest_ptr,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    logic [ID_W-1:0] idx;

    // Scan from the lowest priority upward so the last hit is the highest priority.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_IRQ; k >= 1; k--) begin
            idx = lowest_ptr + ID_W'(k);
            if (req[idx]) begin
                id    = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_prio_core.sv
// Priority-interrupt core: IRR/ISR/IMR, rotating priority and two-pulse acknowledge.
module pic_prio_core
    import pic_pkg::*;
#(
    parameter  int N_IRQ = 8,
    localparam int ID_W  = $clog2(N_IRQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq,
    input  logic [N_IRQ-1:0]     level_mode,
    input  logic                 rotate_en,
    input  logic                 auto_eoi,
    input  logic                 imr_we,
    input  logic [N_IRQ-1:0]     imr_wdata,
    input  logic [VEC_W-ID_W-1:0] vec_base,
    input  logic                 eoi,
    input  logic                 inta,
    output logic                 int_out,
    output logic [VEC_W-1:0]     vector,
    output logic                 vector_valid,
    output logic [N_IRQ-1:0]     irr,
    output logic [N_IRQ-1:0]     isr,
    output logic [N_IRQ-1:0]     imr
);

    pic_state_t       state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] set_vec;
    logic [N_IRQ-1:0] irr_clr;
    logic [N_IRQ-1:0] irr_n;
    logic [N_IRQ-1:0] isr_n;
    logic [ID_W-1:0]  lowest_ptr;
    logic [ID_W-1:0]  ptr_n;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  isr_id;
    logic [ID_W-1:0]  ack_id;
    logic             win_valid;
    logic             isr_valid;
    logic             valid_winner;
    logic             spurious;

    assign pend = irr & ~imr;

    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_req_res (
        .req        (pend),
        .lowest_ptr (lowest_ptr),
        .id         (win_id),
        .valid      (win_valid)
    );

    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_isr_res (
        .req        (isr),
        .lowest_ptr (lowest_ptr),
        .id         (isr_id),
        .valid      (isr_valid)
    );

    always_comb begin
        valid_winner = win_valid;
        if (win_valid && isr_valid)
            valid_winner = prio_rank(int'(win_id), int'(lowest_ptr), N_IRQ)
                         < prio_rank(int'(isr_id), int'(lowest_ptr), N_IRQ);
    end

    // EOI clear is applied before the acknowledge set; a new request beats an ack clear.
    always_comb begin
        isr_n   = isr;
        ptr_n   = lowest_ptr;
        irr_clr = '0;
        if (eoi && isr_valid) begin
            isr_n[isr_id] = 1'b0;
            if (rotate_en)
                ptr_n = isr_id;
        end
        if (state == ST_IDLE && inta && valid_winner) begin
            isr_n[win_id]   = 1'b1;
            irr_clr[win_id] = 1'b1;
        end
        if (state == ST_ACK1 && inta && auto_eoi && !spurious) begin
            isr_n[ack_id] = 1'b0;
            if (rotate_en)
                ptr_n = ack_id;
        end
        set_vec = irq & (level_mode | ~irq_q);
        irr_n   = (irr & ~level_mode & ~irr_clr) | set_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            irq_q        <= '0;
            irr          <= '0;
            isr          <= '0;
            imr          <= '0;
            lowest_ptr   <= ID_W'(N_IRQ - 1);
            ack_id       <= '0;
            spurious     <= 1'b0;
            int_out      <= 1'b0;
            vector       <= '0;
            vector_valid <= 1'b0;
        end else begin
            irq_q        <= irq;
            irr          <= irr_n;
            isr          <= isr_n;
            lowest_ptr   <= ptr_n;
            if (imr_we)
                imr <= imr_wdata;
            vector_valid <= 1'b0;
            int_out      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (inta) begin
                        state    <= ST_ACK1;
                        ack_id   <= valid_winner ? win_id : ID_W'(N_IRQ - 1);
                        spurious <= !valid_winner;
                    end else begin
                        int_out  <= valid_winner;
                    end
                end
                ST_ACK1: begin
                    if (inta) begin
                        state        <= ST_ACK2;
                        vector       <= {vec_base, ack_id};
                        vector_valid <= 1'b1;
                    end
                end
                ST_ACK2: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_prio_core.sv
// Self-checking bench for pic_prio_core: vector table, handshake sequences and a vector scoreboard.
module tb_pic_prio_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  irq, level_mode, imr_wdata;
    logic        rotate_en, auto_eoi, imr_we, eoi, inta;
    logic [4:0]  vec_base;
    logic        int_out, vector_valid;
    logic [7:0]  vector, irr, isr, imr;

    logic [15:0] irq_w, level_w, imr_wdata_w;
    logic        imr_we_w, eoi_w, inta_w;
    logic [3:0]  vec_base_w;
    logic        int_out_w, vector_valid_w;
    logic [7:0]  vector_w;
    logic [15:0] irr_w, isr_w, imr_w;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb8[$];
    logic [7:0] sb16[$];

    pic_prio_core #(.N_IRQ(8)) dut8 (
        .clk(clk), .reset(reset), .irq(irq), .level_mode(level_mode),
        .rotate_en(rotate_en), .auto_eoi(auto_eoi), .imr_we(imr_we),
        .imr_wdata(imr_wdata), .vec_base(vec_base), .eoi(eoi), .inta(inta),
        .int_out(int_out), .vector(vector), .vector_valid(vector_valid),
        .irr(irr), .isr(isr), .imr(imr)
    );

    pic_prio_core #(.N_IRQ(16)) dut16 (
        .clk(clk), .reset(reset), .irq(irq_w), .level_mode(level_w),
        .rotate_en(1'b0), .auto_eoi(1'b0), .imr_we(imr_we_w),
        .imr_wdata(imr_wdata_w), .vec_base(vec_base_w), .eoi(eoi_w), .inta(inta_w),
        .int_out(int_out_w), .vector(vector_w), .vector_valid(vector_valid_w),
        .irr(irr_w), .isr(isr_w), .imr(imr_w)
    );

    typedef struct {
        logic [7:0] irq;
        logic [7:0] level;
        logic [7:0] mask;
        logic [7:0] exp_irr;
        logic       exp_int;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
    } vec_rec_t;

    vec_rec_t tbl[5];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Vectors are compared against the scoreboard whenever either core presents one.
    always @(negedge clk) begin
        if (vector_valid === 1'b1) begin
            if (sb8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL vector8_unexpected: got %0h, expected no vector", vector);
            end else
                check_output("vector8", 32'(vector), 32'(sb8.pop_front()));
        end
        if (vector_valid_w === 1'b1) begin
            if (sb16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL vector16_unexpected: got %0h, expected no vector", vector_w);
            end else
                check_output("vector16", 32'(vector_w), 32'(sb16.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] pulse);
        irq = pulse;
        step();
        irq = '0;
        step();
    endtask

    task automatic ack8(input logic [7:0] exp_vec);
        sb8.push_back(exp_vec);
        inta = 1'b1; step();
        inta = 1'b0; step();
        inta = 1'b1; step();
        inta = 1'b0; step();
    endtask

    task automatic eoi8();
        eoi = 1'b1; step();
        eoi = 1'b0; step();
    endtask

    initial begin
        reset = 1'b1;
        irq = '0; level_mode = '0; imr_wdata = '0; rotate_en = 1'b0; auto_eoi = 1'b0;
        imr_we = 1'b0; eoi = 1'b0; inta = 1'b0; vec_base = 5'b11111;
        irq_w = '0; level_w = '0; imr_wdata_w = '0; imr_we_w = 1'b0; eoi_w = 1'b0;
        inta_w = 1'b0; vec_base_w = 4'hA;

        tbl[0] = '{8'h10, 8'h00, 8'h00, 8'h10, 1'b1, 8'hFC, 8'h10};
        tbl[1] = '{8'h02, 8'h00, 8'h02, 8'h02, 1'b0, 8'h00, 8'h00};
        tbl[2] = '{8'h81, 8'h00, 8'h01, 8'h81, 1'b1, 8'hFF, 8'h80};
        tbl[3] = '{8'h0C, 8'hFF, 8'h00, 8'h0C, 1'b1, 8'hFA, 8'h04};
        tbl[4] = '{8'h60, 8'h00, 8'h20, 8'h60, 1'b1, 8'hFE, 8'h40};

        step();
        check_output("rst_int_out", 32'(int_out), 32'(0));
        check_output("rst_vector_valid", 32'(vector_valid), 32'(0));
        check_output("rst_vector", 32'(vector), 32'(0));
        check_output("rst_irr", 32'(irr), 32'(0));
        check_output("rst_isr", 32'(isr), 32'(0));
        check_output("rst_imr", 32'(imr), 32'(0));
        reset = 1'b0;
        step();

        // Table: single-edge response, mask, then one acknowledge and EOI.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            imr_wdata = tbl[i].mask; level_mode = tbl[i].level; imr_we = 1'b1;
            step();
            imr_we = 1'b0;
            check_output($sformatf("tbl%0d_imr", i), 32'(imr), 32'(tbl[i].mask));
            irq = tbl[i].irq;
            step();
            check_output($sformatf("tbl%0d_irr", i), 32'(irr), 32'(tbl[i].exp_irr));
            check_output($sformatf("tbl%0d_int_early", i), 32'(int_out), 32'(0));
            step();
            check_output($sformatf("tbl%0d_int", i), 32'(int_out), 32'(tbl[i].exp_int));
            if (tbl[i].exp_int) begin
                ack8(tbl[i].exp_vec);
                check_output($sformatf("tbl%0d_isr", i), 32'(isr), 32'(tbl[i].exp_isr));
                eoi8();
                check_output($sformatf("tbl%0d_isr_eoi", i), 32'(isr), 32'(0));
            end
            irq = '0; level_mode = '0;
            step();
        end

        // Fixed priority: 4, 6, 7 in turn.
        do_reset();
        apply_stimulus(8'hD0);
        check_output("fix_int", 32'(int_out), 32'(1));
        ack8(8'hFC);
        check_output("fix_isr4", 32'(isr), 32'(8'h10));
        check_output("fix_irr", 32'(irr), 32'(8'hC0));
        eoi8();
        check_output("fix_int2", 32'(int_out), 32'(1));
        ack8(8'hFE);
        eoi8();
        ack8(8'hFF);
        eoi8();
        check_output("fix_irr_end", 32'(irr), 32'(0));

        // Rotating priority: after servicing 2, channel 3 outranks 1.
        do_reset();
        rotate_en = 1'b1;
        apply_stimulus(8'h04);
        ack8(8'hFA);
        eoi8();
        apply_stimulus(8'h0A);
        ack8(8'hFB);
        check_output("rot_isr3", 32'(isr), 32'(8'h08));
        eoi8();
        ack8(8'hF9);
        eoi8();
        check_output("rot_isr_end", 32'(isr), 32'(0));
        rotate_en = 1'b0;

        // Nesting: ISR 3 blocks 5 but admits 1.
        do_reset();
        apply_stimulus(8'h08);
        ack8(8'hFB);
        apply_stimulus(8'h20);
        check_output("nest_blocked", 32'(int_out), 32'(0));
        apply_stimulus(8'h02);
        check_output("nest_admit", 32'(int_out), 32'(1));
        ack8(8'hF9);
        check_output("nest_isr", 32'(isr), 32'(8'h0A));
        eoi8();
        check_output("nest_eoi1", 32'(isr), 32'(8'h08));
        eoi8();
        check_output("nest_int5", 32'(int_out), 32'(1));
        ack8(8'hFD);
        eoi8();
        check_output("nest_isr_end", 32'(isr), 32'(0));

        // Spurious acknowledge on a level channel that drops, then auto-EOI.
        do_reset();
        level_mode = 8'hFF;
        irq = 8'h01;
        step(); step();
        check_output("spur_int", 32'(int_out), 32'(1));
        irq = '0;
        step();
        ack8(8'hFF);
        check_output("spur_isr", 32'(isr), 32'(0));
        auto_eoi = 1'b1;
        irq = 8'h04;
        step(); step();
        sb8.push_back(8'hFA);
        inta = 1'b1; step();
        check_output("aeoi_isr_set", 32'(isr), 32'(8'h04));
        irq = '0; inta = 1'b0; step();
        inta = 1'b1; step();
        check_output("aeoi_isr_clr", 32'(isr), 32'(0));
        inta = 1'b0; step();
        auto_eoi = 1'b0; level_mode = '0;

        // Reset between the two acknowledge strobes.
        do_reset();
        imr_wdata = 8'h80; imr_we = 1'b1; step(); imr_we = 1'b0;
        apply_stimulus(8'h40);
        inta = 1'b1; step();
        inta = 1'b0; step();
        reset = 1'b1;
        #2;
        check_output("mid_rst_int", 32'(int_out), 32'(0));
        check_output("mid_rst_isr", 32'(isr), 32'(0));
        check_output("mid_rst_irr", 32'(irr), 32'(0));
        check_output("mid_rst_imr", 32'(imr), 32'(0));
        check_output("mid_rst_vv", 32'(vector_valid), 32'(0));
        check_output("mid_rst_vec", 32'(vector), 32'(0));
        step();
        reset = 1'b0;
        apply_stimulus(8'h04);
        ack8(8'hFA);
        eoi8();

        // Sixteen-channel core: channel 13 with base 4'hA.
        irq_w = 16'h2000; step();
        irq_w = '0; step();
        check_output("w16_int", 32'(int_out_w), 32'(1));
        sb16.push_back(8'hAD);
        inta_w = 1'b1; step();
        inta_w = 1'b0; step();
        inta_w = 1'b1; step();
        inta_w = 1'b0; step();
        check_output("w16_isr", 32'(isr_w), 32'(16'h2000));
        eoi_w = 1'b1; step(); eoi_w = 1'b0; step();
        check_output("w16_isr_eoi", 32'(isr_w), 32'(0));

        step(); step();
        check_output("sb8_drained", 32'(sb8.size()), 32'(0));
        check_output("sb16_drained", 32'(sb16.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
